pf_lpddr3_dm_dly_ctrl: RTL and testbench

PF_LPDDR3_DM_DLY_CTRL -- requirements
Module: pf_lpddr3_dm_dly_ctrl

---
 rtl/pf_lpddr3_dly_pkg.sv | 20 ++
 rtl/pf_lpddr3_dly_arb.sv | 29 ++
 rtl/pf_lpddr3_dm_dly_ctrl.sv | 150 +++++++++++++++
 tb/tb_pf_lpddr3_dm_dly_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pf_lpddr3_dly_pkg.sv
// rtl/pf_lpddr3_dly_pkg.sv - shared types and constants for the LPDDR3 DM delay-line controller
package pf_lpddr3_dly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOAD,
        ST_MOVE,
        ST_SETTLE,
        ST_DONE
    } dly_state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Requester indices: training has fixed priority over VT compensation
    localparam logic REQ_TRN = 1'b0;
    localparam logic REQ_VTC = 1'b1;

endpackage

// File: rtl/pf_lpddr3_dly_arb.sv
// rtl/pf_lpddr3_dly_arb.sv - 2-way fixed-priority arbiter with grant register
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration window (controller idle)
//   req[1:0]   : requests, bit 0 has priority
//   sel        : combinational winner index for the current cycle
//   gnt[1:0]   : registered one-hot grant, held until the next arbitration
module pf_lpddr3_dly_arb
    import pf_lpddr3_dly_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic       sel,
    output logic [1:0] gnt
);

    assign sel = req[REQ_TRN] ? REQ_TRN : REQ_VTC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= 2'b00;
        end else if (en && (|req)) begin
            gnt <= (sel == REQ_VTC) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/pf_lpddr3_dm_dly_ctrl.sv
// rtl/pf_lpddr3_dm_dly_ctrl.sv - arbitrated load/step sequencer for the LPDDR3 DM IOD delay line
// Ports:
//   FAB_CLK, ARST_N            : clock, asynchronous active-low reset
//   REQ, REQ_LOAD, REQ_DIR     : per-requester request, load/step select, step direction
//   REQ_STEPS                  : step counts, [7:0] requester 0, [15:8] requester 1
//   ACK                        : one-cycle completion pulse to the granted requester
//   DELAY_LINE_*_0             : IOD load/move/direction controls and range flag
//   TAP_CNT, BUSY, OOR_ERR     : tap estimate, activity flag, sticky range error
module pf_lpddr3_dm_dly_ctrl
    import pf_lpddr3_dly_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] INIT_TAP      = 8'd1,
    parameter logic [7:0] MAX_TAP       = 8'd127
) (
    input  logic        FAB_CLK,
    input  logic        ARST_N,
    input  logic [1:0]  REQ,
    input  logic [1:0]  REQ_LOAD,
    input  logic [1:0]  REQ_DIR,
    input  logic [15:0] REQ_STEPS,
    output logic [1:0]  ACK,
    output logic        DELAY_LINE_LOAD_0,
    output logic        DELAY_LINE_MOVE_0,
    output logic        DELAY_LINE_DIRECTION_0,
    input  logic        DELAY_LINE_OUT_OF_RANGE_0,
    output logic [7:0]  TAP_CNT,
    output logic        BUSY,
    output logic        OOR_ERR
);

    dly_state_t state;
    logic       cmd_load;
    logic       cmd_dir;
    logic [7:0] steps_left;
    logic [3:0] settle_cnt;
    logic       abort;
    logic       arb_en;
    logic       sel_idx;
    logic [1:0] gnt;
    logic       at_limit;

    assign arb_en = (state == ST_IDLE);
    assign BUSY   = (state != ST_IDLE);

    // A move that would push the tap estimate past either end is refused
    assign at_limit = ((cmd_dir == DIR_INC) && (TAP_CNT == MAX_TAP)) ||
                      ((cmd_dir == DIR_DEC) && (TAP_CNT == 8'd0));

    pf_lpddr3_dly_arb u_arb (
        .clk   (FAB_CLK),
        .rst_n (ARST_N),
        .en    (arb_en),
        .req   (REQ),
        .sel   (sel_idx),
        .gnt   (gnt)
    );

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                  <= ST_IDLE;
            cmd_load               <= 1'b0;
            cmd_dir                <= DIR_DEC;
            steps_left             <= 8'd0;
            settle_cnt             <= 4'd0;
            abort                  <= 1'b0;
            ACK                    <= 2'b00;
            DELAY_LINE_LOAD_0      <= 1'b0;
            DELAY_LINE_MOVE_0      <= 1'b0;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
            TAP_CNT                <= INIT_TAP;
            OOR_ERR                <= 1'b0;
        end else begin
            // Pulse outputs default low so every pulse is exactly one cycle
            DELAY_LINE_LOAD_0 <= 1'b0;
            DELAY_LINE_MOVE_0 <= 1'b0;
            ACK               <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        state      <= ST_GRANT;
                        cmd_load   <= REQ_LOAD[sel_idx];
                        cmd_dir    <= REQ_DIR[sel_idx];
                        steps_left <= (sel_idx == REQ_VTC) ? REQ_STEPS[15:8] : REQ_STEPS[7:0];
                        abort      <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    DELAY_LINE_DIRECTION_0 <= cmd_dir;
                    if (cmd_load) begin
                        state             <= ST_LOAD;
                        DELAY_LINE_LOAD_0 <= 1'b1;
                        TAP_CNT           <= INIT_TAP;
                        OOR_ERR           <= 1'b0;
                    end else if (steps_left == 8'd0) begin
                        state <= ST_DONE;
                        ACK   <= gnt;
                    end else begin
                        state <= ST_MOVE;
                    end
                end
                ST_LOAD: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= 4'(SETTLE_CYCLES - 1);
                end
                // Decision cycle: the pulse itself appears in the first SETTLE cycle,
                // so consecutive pulses are SETTLE_CYCLES+1 apart
                ST_MOVE: begin
                    if (steps_left == 8'd0) begin
                        state <= ST_DONE;
                        ACK   <= gnt;
                    end else if (at_limit) begin
                        state   <= ST_DONE;
                        OOR_ERR <= 1'b1;
                        ACK     <= gnt;
                    end else begin
                        state             <= ST_SETTLE;
                        settle_cnt        <= 4'(SETTLE_CYCLES - 1);
                        DELAY_LINE_MOVE_0 <= 1'b1;
                        TAP_CNT           <= (cmd_dir == DIR_INC) ? TAP_CNT + 8'd1 : TAP_CNT - 8'd1;
                        steps_left        <= steps_left - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        abort   <= 1'b1;
                        OOR_ERR <= 1'b1;
                    end
                    if (settle_cnt == 4'd0) begin
                        if (cmd_load || abort || DELAY_LINE_OUT_OF_RANGE_0) begin
                            state <= ST_DONE;
                            ACK   <= gnt;
                        end else begin
                            state <= ST_MOVE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pf_lpddr3_dm_dly_ctrl.sv
// tb/tb_pf_lpddr3_dm_dly_ctrl.sv - directed self-checking bench for pf_lpddr3_dm_dly_ctrl
module tb_pf_lpddr3_dm_dly_ctrl;

    logic        FAB_CLK;
    logic        ARST_N;
    logic [1:0]  REQ;
    logic [1:0]  REQ_LOAD;
    logic [1:0]  REQ_DIR;
    logic [15:0] REQ_STEPS;
    logic [1:0]  ACK;
    logic        DELAY_LINE_LOAD_0;
    logic        DELAY_LINE_MOVE_0;
    logic        DELAY_LINE_DIRECTION_0;
    logic        DELAY_LINE_OUT_OF_RANGE_0;
    logic [7:0]  TAP_CNT;
    logic        BUSY;
    logic        OOR_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent run_cmd, cycle 0 = the GRANT cycle
    int         load_at, load_n, move_n, ack_at;
    int         move_at[8];
    logic [7:0] tap_at[8];
    logic [1:0] ack_val, post_ack;
    logic       post_busy, g_busy, dir_bad, both_bad;

    pf_lpddr3_dm_dly_ctrl #(
        .SETTLE_CYCLES (4),
        .INIT_TAP      (8'd1),
        .MAX_TAP       (8'd127)
    ) dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .REQ                       (REQ),
        .REQ_LOAD                  (REQ_LOAD),
        .REQ_DIR                   (REQ_DIR),
        .REQ_STEPS                 (REQ_STEPS),
        .ACK                       (ACK),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
        .TAP_CNT                   (TAP_CNT),
        .BUSY                      (BUSY),
        .OOR_ERR                   (OOR_ERR)
    );

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    task automatic run_cmd(input int idx, input bit ld, input bit dr, input int steps, input int oor_after);
        int k;
        @(negedge FAB_CLK);
        REQ_LOAD[idx] = ld;
        REQ_DIR[idx]  = dr;
        if (idx == 0) REQ_STEPS[7:0] = steps[7:0];
        else          REQ_STEPS[15:8] = steps[7:0];
        REQ[idx] = 1'b1;
        @(posedge FAB_CLK); #1;
        k = 0; load_at = -1; load_n = 0; move_n = 0; ack_at = -1; ack_val = 2'b00;
        dir_bad = 1'b0; both_bad = 1'b0; g_busy = BUSY;
        while (ack_at < 0 && k < 2000) begin
            @(posedge FAB_CLK); #1;
            k++;
            if (DELAY_LINE_LOAD_0) begin load_at = k; load_n++; end
            if (DELAY_LINE_MOVE_0) begin
                if (move_n < 8) begin move_at[move_n] = k; tap_at[move_n] = TAP_CNT; end
                move_n++;
                if (oor_after != 0 && move_n == oor_after) DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
            end
            if (DELAY_LINE_LOAD_0 && DELAY_LINE_MOVE_0) both_bad = 1'b1;
            if (DELAY_LINE_DIRECTION_0 !== dr) dir_bad = 1'b1;
            if (ACK !== 2'b00) begin ack_at = k; ack_val = ACK; REQ[idx] = 1'b0; end
        end
        if (ack_at < 0) REQ[idx] = 1'b0;
        @(posedge FAB_CLK); #1;
        post_ack = ACK; post_busy = BUSY;
    endtask

    task automatic test_reset;
        ARST_N = 1'b0; REQ = 2'b00; REQ_LOAD = 2'b00; REQ_DIR = 2'b00; REQ_STEPS = 16'h0;
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        repeat (3) @(posedge FAB_CLK);
        #1;
        n_checks++; if (TAP_CNT !== 8'd1) begin n_fail++; $display("FAIL reset_tap: got %0d expected 1", TAP_CNT); end
        n_checks++; if ({ACK, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, OOR_ERR, BUSY} !== 7'b0)
            begin n_fail++; $display("FAIL reset_outs: got ack=%b ld=%b mv=%b dir=%b oor=%b busy=%b expected all 0",
                ACK, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, OOR_ERR, BUSY); end
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
    endtask

    task automatic test_load;
        run_cmd(0, 1'b1, 1'b0, 0, 0);
        n_checks++; if (g_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_at_g: got %b expected 1", g_busy); end
        n_checks++; if (load_at !== 1 || load_n !== 1) begin n_fail++; $display("FAIL load_pulse: got at=%0d n=%0d expected at=1 n=1", load_at, load_n); end
        n_checks++; if (TAP_CNT !== 8'd1) begin n_fail++; $display("FAIL load_tap: got %0d expected 1", TAP_CNT); end
        n_checks++; if (ack_at !== 6 || ack_val !== 2'b01) begin n_fail++; $display("FAIL load_ack: got at=%0d val=%b expected at=6 val=01", ack_at, ack_val); end
        n_checks++; if (move_n !== 0 || post_ack !== 2'b00 || post_busy !== 1'b0) begin n_fail++; $display("FAIL load_after: got moves=%0d ack=%b busy=%b expected 0 00 0", move_n, post_ack, post_busy); end
    endtask

    task automatic test_step_inc;
        run_cmd(1, 1'b0, 1'b1, 3, 0);
        n_checks++; if (move_n !== 3) begin n_fail++; $display("FAIL inc_move_count: got %0d expected 3", move_n); end
        n_checks++; if (move_at[0] !== 2 || move_at[1] !== 7 || move_at[2] !== 12)
            begin n_fail++; $display("FAIL inc_move_times: got %0d %0d %0d expected 2 7 12", move_at[0], move_at[1], move_at[2]); end
        n_checks++; if (tap_at[0] !== 8'd2 || tap_at[1] !== 8'd3 || tap_at[2] !== 8'd4)
            begin n_fail++; $display("FAIL inc_tap_steps: got %0d %0d %0d expected 2 3 4", tap_at[0], tap_at[1], tap_at[2]); end
        n_checks++; if (ack_at !== 17 || ack_val !== 2'b10) begin n_fail++; $display("FAIL inc_ack: got at=%0d val=%b expected at=17 val=10", ack_at, ack_val); end
        n_checks++; if (dir_bad !== 1'b0 || both_bad !== 1'b0 || load_n !== 0) begin n_fail++; $display("FAIL inc_ctrl: got dir_bad=%b both=%b loads=%0d expected 0 0 0", dir_bad, both_bad, load_n); end
    endtask

    task automatic test_steps_zero;
        run_cmd(0, 1'b0, 1'b1, 0, 0);
        n_checks++; if (ack_at !== 1 || ack_val !== 2'b01 || move_n !== 0) begin n_fail++; $display("FAIL zero_steps: got at=%0d val=%b moves=%0d expected 1 01 0", ack_at, ack_val, move_n); end
        n_checks++; if (TAP_CNT !== 8'd4) begin n_fail++; $display("FAIL zero_steps_tap: got %0d expected 4", TAP_CNT); end
    endtask

    task automatic test_priority;
        int k, n;
        logic [1:0] acks[2];
        int at[2];
        logic overlap;
        n = 0; k = 0; overlap = 1'b0; acks[0] = 2'b00; acks[1] = 2'b00; at[0] = -1; at[1] = -1;
        @(negedge FAB_CLK);
        REQ_LOAD = 2'b01; REQ_DIR = 2'b10; REQ_STEPS = 16'h0100;
        REQ = 2'b11;
        @(posedge FAB_CLK); #1;
        while (n < 2 && k < 200) begin
            @(posedge FAB_CLK); #1;
            k++;
            if (DELAY_LINE_LOAD_0 && DELAY_LINE_MOVE_0) overlap = 1'b1;
            if (ACK !== 2'b00) begin
                if (ACK === 2'b11) overlap = 1'b1;
                acks[n] = ACK; at[n] = k; n++;
                REQ = REQ & ~ACK;
            end
        end
        REQ = 2'b00;
        n_checks++; if (acks[0] !== 2'b01 || at[0] !== 6) begin n_fail++; $display("FAIL prio_first: got %b at %0d expected 01 at 6", acks[0], at[0]); end
        n_checks++; if (acks[1] !== 2'b10 || at[1] !== 15) begin n_fail++; $display("FAIL prio_second: got %b at %0d expected 10 at 15", acks[1], at[1]); end
        n_checks++; if (overlap !== 1'b0 || TAP_CNT !== 8'd2) begin n_fail++; $display("FAIL prio_result: got overlap=%b tap=%0d expected 0 2", overlap, TAP_CNT); end
        @(posedge FAB_CLK); #1;
    endtask

    task automatic test_upper_bound;
        run_cmd(0, 1'b1, 1'b0, 0, 0);
        run_cmd(1, 1'b0, 1'b1, 125, 0);
        n_checks++; if (TAP_CNT !== 8'd126 || move_n !== 125 || OOR_ERR !== 1'b0)
            begin n_fail++; $display("FAIL upper_prep: got tap=%0d moves=%0d oor=%b expected 126 125 0", TAP_CNT, move_n, OOR_ERR); end
        run_cmd(1, 1'b0, 1'b1, 5, 0);
        n_checks++; if (move_n !== 1 || TAP_CNT !== 8'd127) begin n_fail++; $display("FAIL upper_clip: got moves=%0d tap=%0d expected 1 127", move_n, TAP_CNT); end
        n_checks++; if (OOR_ERR !== 1'b1 || ack_at !== 7 || post_ack !== 2'b00) begin n_fail++; $display("FAIL upper_err: got oor=%b ack_at=%0d post=%b expected 1 7 00", OOR_ERR, ack_at, post_ack); end
    endtask

    task automatic test_lower_bound;
        run_cmd(0, 1'b1, 1'b0, 0, 0);
        n_checks++; if (OOR_ERR !== 1'b0) begin n_fail++; $display("FAIL lower_load_clear: got %b expected 0", OOR_ERR); end
        run_cmd(0, 1'b0, 1'b0, 3, 0);
        n_checks++; if (move_n !== 1 || TAP_CNT !== 8'd0 || OOR_ERR !== 1'b1) begin n_fail++; $display("FAIL lower_clip: got moves=%0d tap=%0d oor=%b expected 1 0 1", move_n, TAP_CNT, OOR_ERR); end
    endtask

    task automatic test_oor_abort;
        run_cmd(0, 1'b1, 1'b0, 0, 0);
        run_cmd(0, 1'b0, 1'b1, 10, 0);
        n_checks++; if (TAP_CNT !== 8'd11 || OOR_ERR !== 1'b0) begin n_fail++; $display("FAIL abort_prep: got tap=%0d oor=%b expected 11 0", TAP_CNT, OOR_ERR); end
        run_cmd(1, 1'b0, 1'b0, 6, 2);
        n_checks++; if (move_n !== 2 || TAP_CNT !== 8'd9) begin n_fail++; $display("FAIL abort_moves: got moves=%0d tap=%0d expected 2 9", move_n, TAP_CNT); end
        n_checks++; if (OOR_ERR !== 1'b1 || ack_at !== 11 || ack_val !== 2'b10) begin n_fail++; $display("FAIL abort_ack: got oor=%b at=%0d val=%b expected 1 11 10", OOR_ERR, ack_at, ack_val); end
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        run_cmd(0, 1'b1, 1'b0, 0, 0);
        n_checks++; if (OOR_ERR !== 1'b0 || TAP_CNT !== 8'd1) begin n_fail++; $display("FAIL abort_reload: got oor=%b tap=%0d expected 0 1", OOR_ERR, TAP_CNT); end
    endtask

    task automatic test_reset_mid;
        int k, moves;
        logic saw_ack;
        moves = 0; k = 0; saw_ack = 1'b0;
        @(negedge FAB_CLK);
        REQ_LOAD[1] = 1'b0; REQ_DIR[1] = 1'b1; REQ_STEPS[15:8] = 8'd5; REQ[1] = 1'b1;
        @(posedge FAB_CLK); #1;
        while (moves < 1 && k < 100) begin
            @(posedge FAB_CLK); #1;
            k++;
            if (DELAY_LINE_MOVE_0) moves++;
        end
        @(posedge FAB_CLK); #1;
        ARST_N = 1'b0;
        #1;
        n_checks++; if ({ACK, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, OOR_ERR, BUSY} !== 7'b0 || TAP_CNT !== 8'd1)
            begin n_fail++; $display("FAIL midreset_outs: got ack=%b ld=%b mv=%b dir=%b oor=%b busy=%b tap=%0d expected zeros tap=1",
                ACK, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, OOR_ERR, BUSY, TAP_CNT); end
        REQ = 2'b00;
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge FAB_CLK); #1;
            if (ACK !== 2'b00 || DELAY_LINE_MOVE_0 !== 1'b0 || BUSY !== 1'b0) saw_ack = 1'b1;
        end
        n_checks++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet: got activity=%b expected 0", saw_ack); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step_inc();
        test_steps_zero();
        test_priority();
        test_upper_bound();
        test_lower_bound();
        test_oor_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
